// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK symbol scheduler and its rate pacer.
// State encoding is fixed so debug taps and checkers can decode it directly.
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } qpsk_state_e;

  localparam int QPSK_DATA_WIDTH = 16;
  localparam int SYMS_PER_BYTE   = 4;
  localparam int SYM_CNT_W       = $clog2(SYMS_PER_BYTE);

  // Appends a 2-bit symbol at the LSB end so the first symbol of a byte lands in [7:6].
  function automatic logic [7:0] pack_sym(input logic [7:0] acc, input logic [1:0] sym);
    return {acc[5:0], sym};
  endfunction

endpackage

// File: rtl/qpsk_rate_pacer.sv
// Symbol-rate pacer: free-running slot counter with a one-cycle slot_tick at the end
// of each interval of BASE_DIV*(rate_sel+1) clocks; idles at zero while disabled.
module qpsk_rate_pacer #(
  parameter int BASE_DIV = 1024,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] rate_sel,
  output logic       slot_tick
);

  logic [CNT_W-1:0] count_q;
  logic [3:0]       rate_q;
  logic [CNT_W-1:0] last_d;

  assign last_d    = CNT_W'(BASE_DIV) * (CNT_W'(rate_q) + CNT_W'(1)) - CNT_W'(1);
  assign slot_tick = enable && (count_q == last_d);

  // rate_sel is only adopted on a wrap; reset and disable count as wraps so the
  // first interval after either already uses the requested rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rate_q  <= rate_sel;
    end else if (!enable) begin
      count_q <= '0;
      rate_q  <= rate_sel;
    end else if (slot_tick) begin
      count_q <= '0;
      rate_q  <= rate_sel;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Paces and round-robin arbitrates I/Q symbol issue into the QPSK demodulator,
// tracks the outstanding symbol until response or timeout, and packs results into bytes.
module qpsk_symbol_scheduler
  import qpsk_pkg::*;
#(
  parameter int DATA_WIDTH = QPSK_DATA_WIDTH,
  parameter int BASE_DIV   = 1024,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            rate_sel,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_i,
  input  logic [DATA_WIDTH-1:0] req0_q,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_i,
  input  logic [DATA_WIDTH-1:0] req1_q,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] demod_i,
  output logic [DATA_WIDTH-1:0] demod_q,
  output logic                  demod_valid,
  input  logic [1:0]            demod_bit,
  input  logic                  demod_bit_valid,
  input  logic                  demod_error,
  output logic                  grant_id,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic                  byte_err,
  output logic                  timeout_pulse,
  output logic                  busy,
  output qpsk_state_e           dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: reqN_ready is a one-cycle accept pulse; a sample is taken in the cycle
  // where reqN_valid and reqN_ready are both high. demod_valid is a one-cycle strobe
  // with no back-pressure, and demod_bit_valid is honoured only while a symbol is outstanding.
  qpsk_state_e          state_q;
  logic [TW-1:0]        timer_q;
  logic                 last_grant_q;
  logic                 grant_id_q;
  logic [DATA_WIDTH-1:0] demod_i_q;
  logic [DATA_WIDTH-1:0] demod_q_q;
  logic                 demod_valid_q;
  logic [7:0]           pack_q;
  logic                 err_acc_q;
  logic [SYM_CNT_W-1:0] sym_cnt_q;
  logic [7:0]           byte_out_q;
  logic                 byte_valid_q;
  logic                 byte_err_q;
  logic                 timeout_q;

  logic                 slot_tick;
  logic                 grant_d;
  logic                 go_d;
  logic [7:0]           pack_d;
  logic                 last_sym_d;

  qpsk_rate_pacer #(
    .BASE_DIV (BASE_DIV),
    .CNT_W    (CNT_W)
  ) u_pacer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rate_sel  (rate_sel),
    .slot_tick (slot_tick)
  );

  // With both requesters valid the one not served last wins; otherwise the valid one.
  assign grant_d    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign go_d       = (state_q == ST_IDLE) && slot_tick && (req0_valid || req1_valid) && !reset;
  assign req0_ready = go_d && !grant_d;
  assign req1_ready = go_d && grant_d;

  assign pack_d     = pack_sym(pack_q, demod_bit);
  assign last_sym_d = (sym_cnt_q == SYM_CNT_W'(SYMS_PER_BYTE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      demod_i_q     <= '0;
      demod_q_q     <= '0;
      demod_valid_q <= 1'b0;
      pack_q        <= '0;
      err_acc_q     <= 1'b0;
      sym_cnt_q     <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      byte_err_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      demod_valid_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go_d) begin
            state_q       <= ST_ISSUE;
            demod_i_q     <= grant_d ? req1_i : req0_i;
            demod_q_q     <= grant_d ? req1_q : req0_q;
            demod_valid_q <= 1'b1;
            grant_id_q    <= grant_d;
            last_grant_q  <= grant_d;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_RESP;
          timer_q <= '0;
        end
        ST_WAIT_RESP: begin
          // A response in the final timer cycle still counts as on time.
          if (demod_bit_valid) begin
            state_q <= ST_IDLE;
            if (last_sym_d) begin
              byte_out_q   <= pack_d;
              byte_err_q   <= err_acc_q | demod_error;
              byte_valid_q <= 1'b1;
              pack_q       <= '0;
              err_acc_q    <= 1'b0;
              sym_cnt_q    <= '0;
            end else begin
              pack_q    <= pack_d;
              err_acc_q <= err_acc_q | demod_error;
              sym_cnt_q <= sym_cnt_q + SYM_CNT_W'(1);
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign demod_i       = demod_i_q;
  assign demod_q       = demod_q_q;
  assign demod_valid   = demod_valid_q;
  assign grant_id      = grant_id_q;
  assign byte_out      = byte_out_q;
  assign byte_valid    = byte_valid_q;
  assign byte_err      = byte_err_q;
  assign timeout_pulse = timeout_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Directed bench for qpsk_symbol_scheduler: pacing, round-robin, packing, timeout,
// simultaneous events, enable drop and mid-transaction reset.
module tb_qpsk_symbol_scheduler;
  import qpsk_pkg::*;

  localparam int DW = 16;
  localparam logic [DW-1:0] I0 = 16'h1234;
  localparam logic [DW-1:0] Q0 = 16'hFEDC;
  localparam logic [DW-1:0] I1 = 16'h8001;
  localparam logic [DW-1:0] Q1 = 16'h0F0F;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    rate_sel = 4'd1;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_i = I0;
  logic [DW-1:0] req0_q = Q0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_i = I1;
  logic [DW-1:0] req1_q = Q1;
  logic          req1_ready;
  logic [DW-1:0] demod_i;
  logic [DW-1:0] demod_q;
  logic          demod_valid;
  logic [1:0]    demod_bit = 2'b00;
  logic          demod_bit_valid = 1'b0;
  logic          demod_error = 1'b0;
  logic          grant_id;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_err;
  logic          timeout_pulse;
  logic          busy;
  qpsk_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  qpsk_symbol_scheduler #(
    .DATA_WIDTH (DW),
    .BASE_DIV   (4),
    .TIMEOUT    (8),
    .CNT_W      (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .rate_sel        (rate_sel),
    .req0_valid      (req0_valid),
    .req0_i          (req0_i),
    .req0_q          (req0_q),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_i          (req1_i),
    .req1_q          (req1_q),
    .req1_ready      (req1_ready),
    .demod_i         (demod_i),
    .demod_q         (demod_q),
    .demod_valid     (demod_valid),
    .demod_bit       (demod_bit),
    .demod_bit_valid (demod_bit_valid),
    .demod_error     (demod_error),
    .grant_id        (grant_id),
    .byte_out        (byte_out),
    .byte_valid      (byte_valid),
    .byte_err        (byte_err),
    .timeout_pulse   (timeout_pulse),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_demod_valid"}, demod_valid, 0);
    chk({tag, "_demod_i"}, demod_i, 0);
    chk({tag, "_demod_q"}, demod_q, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_byte_out"}, byte_out, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_byte_err"}, byte_err, 0);
    chk({tag, "_timeout"}, timeout_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Steps until a ready pulse is seen (bounded) and checks the number of cycles taken.
  task automatic expect_tick(input string tag, input int exp_n);
    int n = 0;
    while (!(req0_ready || req1_ready) && n < 40) begin
      step();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  // Called in a grant cycle: checks the grant, the issue strobe, then returns sym 2 clocks later.
  task automatic do_txn(input logic g, input logic [1:0] sym, input logic err);
    chk("txn_ready0", req0_ready, !g);
    chk("txn_ready1", req1_ready, g);
    step();
    chk("txn_demod_valid", demod_valid, 1);
    chk("txn_grant_id", grant_id, g);
    chk("txn_demod_i", demod_i, g ? I1 : I0);
    chk("txn_demod_q", demod_q, g ? Q1 : Q0);
    step();
    chk("txn_demod_valid_low", demod_valid, 0);
    chk("txn_busy", busy, 1);
    step();
    demod_bit_valid = 1'b1;
    demod_bit = sym;
    demod_error = err;
    step();
    demod_bit_valid = 1'b0;
    demod_error = 1'b0;
  endtask

  task automatic expect_byte(input logic e);
    logic [7:0] exp_b;
    exp_b = exp_q.pop_front();
    chk("byte_valid", byte_valid, 1);
    chk("byte_out", byte_out, exp_b);
    chk("byte_err", byte_err, e);
  endtask

  initial begin
    int n;
    logic saw;

    // Reset state
    repeat (2) step();
    reset = 1'b0;
    check_idle("reset");

    // Pacing and packing: rate 1 -> 8-clock slots, symbols 00,01,11,10 -> 8'h1E
    req0_valid = 1'b1;
    enable = 1'b1;
    expect_tick("first_tick", 7);
    exp_q.push_back(8'h1E);
    do_txn(1'b0, 2'b00, 1'b0);
    expect_tick("pace1", 4);
    chk("byte_valid_idle", byte_valid, 0);
    do_txn(1'b0, 2'b01, 1'b0);
    expect_tick("pace2", 4);
    do_txn(1'b0, 2'b11, 1'b0);
    expect_tick("pace3", 4);
    do_txn(1'b0, 2'b10, 1'b0);
    expect_byte(1'b0);

    // Round-robin after reset (req0 first), error on symbol 2 -> 8'hE4 with byte_err
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst2");
    req1_valid = 1'b1;
    expect_tick("rr_first", 7);
    exp_q.push_back(8'hE4);
    do_txn(1'b0, 2'b11, 1'b0);
    expect_tick("rr1", 4);
    do_txn(1'b1, 2'b10, 1'b1);
    expect_tick("rr2", 4);
    do_txn(1'b0, 2'b01, 1'b0);
    expect_tick("rr3", 4);
    do_txn(1'b1, 2'b00, 1'b0);
    expect_byte(1'b1);

    // Only req1 valid: req1 granted on consecutive slots
    req0_valid = 1'b0;
    expect_tick("r1_a", 4);
    chk("byte_valid_cleared", byte_valid, 0);
    chk("byte_out_held", byte_out, 8'hE4);
    do_txn(1'b1, 2'b00, 1'b0);
    expect_tick("r1_b", 4);
    do_txn(1'b1, 2'b00, 1'b0);

    // Timeout: no response -> pulse TIMEOUT+1 clocks after demod_valid; tick in WAIT dropped
    expect_tick("to_tick", 4);
    chk("to_ready1", req1_ready, 1);
    step();
    chk("to_demod_valid", demod_valid, 1);
    n = 0;
    saw = 1'b0;
    while (!timeout_pulse && n < 40) begin
      step();
      n++;
      saw = saw | req0_ready | req1_ready;
    end
    chk("to_latency", n, 9);
    chk("to_no_grant_in_wait", saw, 0);
    chk("to_busy", busy, 0);
    step();
    chk("to_single_cycle", timeout_pulse, 0);
    // Packer still holds 00,00 from before the timeout
    exp_q.push_back(8'h0D);
    expect_tick("to_next", 5);
    do_txn(1'b1, 2'b11, 1'b0);
    expect_tick("to_next2", 4);
    do_txn(1'b1, 2'b01, 1'b0);
    expect_byte(1'b0);

    // Response in the timeout cycle is accepted, no timeout pulse
    expect_tick("sim_tick", 4);
    step();
    chk("sim_demod_valid", demod_valid, 1);
    repeat (8) step();
    demod_bit_valid = 1'b1;
    demod_bit = 2'b10;
    step();
    demod_bit_valid = 1'b0;
    chk("sim_no_timeout", timeout_pulse, 0);
    chk("sim_idle", busy, 0);
    exp_q.push_back(8'h93);
    expect_tick("sim_next", 6);
    do_txn(1'b1, 2'b01, 1'b0);
    expect_tick("sim_next2", 4);
    do_txn(1'b1, 2'b00, 1'b0);
    expect_tick("sim_next3", 4);
    do_txn(1'b1, 2'b11, 1'b0);
    expect_byte(1'b0);

    // Enable drops mid-transaction: response still taken, no new grants, partial byte kept
    expect_tick("en_tick", 4);
    step();
    chk("en_demod_valid", demod_valid, 1);
    enable = 1'b0;
    step();
    demod_bit_valid = 1'b1;
    demod_bit = 2'b10;
    step();
    demod_bit_valid = 1'b0;
    chk("en_done_idle", busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      saw = saw | req0_ready | req1_ready;
    end
    chk("en_no_grant", saw, 0);
    enable = 1'b1;
    exp_q.push_back(8'h95);
    expect_tick("en_restart", 7);
    do_txn(1'b1, 2'b01, 1'b0);
    expect_tick("en_r2", 4);
    do_txn(1'b1, 2'b01, 1'b0);
    expect_tick("en_r3", 4);
    do_txn(1'b1, 2'b01, 1'b0);
    expect_byte(1'b0);

    // Reset with 2 symbols packed and a symbol outstanding
    expect_tick("mr_a", 4);
    do_txn(1'b1, 2'b11, 1'b0);
    expect_tick("mr_b", 4);
    do_txn(1'b1, 2'b11, 1'b0);
    expect_tick("mr_c", 4);
    step();
    step();
    chk("mr_in_wait", dbg_state, ST_WAIT_RESP);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid_reset");
    exp_q.push_back(8'h1B);
    expect_tick("mr_first", 7);
    do_txn(1'b1, 2'b00, 1'b0);
    expect_tick("mr_1", 4);
    do_txn(1'b1, 2'b01, 1'b0);
    chk("mr_no_early_byte", byte_valid, 0);
    expect_tick("mr_2", 4);
    do_txn(1'b1, 2'b10, 1'b0);
    expect_tick("mr_3", 4);
    do_txn(1'b1, 2'b11, 1'b0);
    expect_byte(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
